// File: rtl/snn_pkg.sv
// snn_pkg: shared FSM type, default parameters and constants for the SNN
// output (decoding) layer.
package snn_pkg;

    // Phases of one classification window.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DECIDE  = 2'd2,
        HOLD    = 2'd3
    } out_state_t;

    localparam int DEF_N_OUT  = 4;
    localparam int DEF_WINDOW = 30;
    localparam int DEF_CNT_W  = 8;

    // Width of the optional discarded-spike counter.
    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/spike_sat_counter.sv
// spike_sat_counter: per-neuron spike counter that holds at its maximum
// value instead of wrapping. A clear takes priority over an increment.
module spike_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    // Count spikes, sticking at CNT_MAX; synchronous reset and clear.
    // NOTE: sequential state is written with <= only, so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    // NOTE: this is a plain register, not a memory, so resetting it is free
    // and keeps the counter deterministic after rst.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/output_layer.sv
// output_layer: counts spikes from the final neuron layer over WINDOW
// snn_clk ticks, picks the neuron with the most spikes (lowest index on a
// tie) by scanning one counter per cycle, and holds the result on a
// valid/ready handshake until it is accepted.
// Optional feature: define OUT_DROP_CNT_EN to add the dropped_count port,
// which totals spikes discarded while deciding or holding a result.
module output_layer
    import snn_pkg::*;
#(
    parameter  int N_OUT  = DEF_N_OUT,
    parameter  int WINDOW = DEF_WINDOW,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int WIN_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  snn_clk,
    input  logic [N_OUT-1:0]      spike_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIN_W-1:0]      winner,
    output logic [CNT_W-1:0]      winner_count,
    output logic                  none
`ifdef OUT_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] dropped_count
`endif
);

    localparam int TICK_W = $clog2(WINDOW + 1);

    out_state_t        r_state;
    out_state_t        w_next_state;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [WIN_W-1:0]  r_scan_idx;
    logic [WIN_W-1:0]  r_best_idx;
    logic [CNT_W-1:0]  r_best_cnt;
    logic [CNT_W-1:0]  w_cnt [N_OUT];
    logic              w_count_en;
    logic              w_accept;
    logic              w_window_close;
    logic              w_scan_last;

    // Spikes count through DRAIN so the one-cycle neuron lag after the
    // closing tick is still captured.
    assign w_count_en     = (r_state == COLLECT) || (r_state == DRAIN);
    assign w_accept       = (r_state == HOLD) && out_ready;
    assign w_window_close = (r_state == COLLECT) && snn_clk &&
                            (r_tick_cnt == TICK_W'(WINDOW - 1));
    assign w_scan_last    = (r_scan_idx == WIN_W'(N_OUT - 1));

    for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
        spike_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .sys_clk (sys_clk),
            .rst     (rst),
            .inc     (w_count_en && spike_in[g]),
            .clr     (w_accept),
            .count   (w_cnt[g])
        );
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment first means every path assigns
    // w_next_state, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            COLLECT: if (w_window_close) w_next_state = DRAIN;
            DRAIN:   w_next_state = DECIDE;
            DECIDE:  if (w_scan_last) w_next_state = HOLD;
            HOLD:    if (out_ready) w_next_state = COLLECT;
            default: w_next_state = COLLECT;
        endcase
    end

    // Outputs: the result is only presented while holding; zero otherwise.
    always_comb begin
        out_valid    = 1'b0;
        winner       = '0;
        winner_count = '0;
        none         = 1'b0;
        if (r_state == HOLD) begin
            out_valid    = 1'b1;
            winner       = r_best_idx;
            winner_count = r_best_cnt;
            none         = (r_best_cnt == '0);
        end
    end

    // Window tick counter and argmax scan; a strict '>' keeps the lowest
    // index on ties, and an all-zero window leaves best at index 0, count 0.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_scan_idx <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (snn_clk) r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                end
                DRAIN: begin
                    r_scan_idx <= '0;
                end
                DECIDE: begin
                    if (w_cnt[r_scan_idx] > r_best_cnt) begin
                        r_best_idx <= r_scan_idx;
                        r_best_cnt <= w_cnt[r_scan_idx];
                    end
                    r_scan_idx <= r_scan_idx + WIN_W'(1);
                end
                HOLD: begin
                    if (out_ready) begin
                        r_tick_cnt <= '0;
                        r_best_idx <= '0;
                        r_best_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef OUT_DROP_CNT_EN
    localparam int DSUM_W = DROP_CNT_W + 1;

    logic [DROP_CNT_W-1:0] r_dropped;
    logic [DSUM_W-1:0]     w_drop_sum;

    // Running total plus the popcount of this cycle's spikes, one bit wider
    // so overflow is visible for saturation.
    always_comb begin
        w_drop_sum = {1'b0, r_dropped};
        for (int i = 0; i < N_OUT; i++) begin
            w_drop_sum = w_drop_sum + DSUM_W'(spike_in[i]);
        end
    end

    // Accumulate spikes discarded while deciding or holding; only rst clears.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_dropped <= '0;
        end else if ((r_state == DECIDE) || (r_state == HOLD)) begin
            r_dropped <= w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
        end
    end

    assign dropped_count = r_dropped;
`endif

endmodule
